// File: rtl/fmaa_pkg.sv
// fmaa_pkg -- shared types and helpers for the fmaa_pipe multiply-add-add unit.
//   fmaa_mode_t : per-operation mode bits {tc, neg_c, neg_d}
//   fmaa_iw     : internal exact-arithmetic width for given operand widths
//   fmaa_smax / fmaa_smin / fmaa_umax : range bounds for an OW-bit result,
//     returned as FMAA_MAXW-bit patterns; callers truncate to their width.
package fmaa_pkg;

    typedef struct packed {
        logic tc;      // 1 = two's complement operands, 0 = unsigned
        logic neg_c;   // subtract c
        logic neg_d;   // subtract d
    } fmaa_mode_t;

    localparam int unsigned FMAA_MAXW = 512;

    function automatic int unsigned fmaa_iw(input int unsigned bw, input int unsigned ow);
        return ((2 * bw > ow) ? 2 * bw : ow) + 2;
    endfunction

    function automatic logic [FMAA_MAXW-1:0] fmaa_smax(input int unsigned ow);
        return (FMAA_MAXW'(1) << (ow - 1)) - FMAA_MAXW'(1);
    endfunction

    // Two's complement of 2^(ow-1); still correct after truncation to any width > ow.
    function automatic logic [FMAA_MAXW-1:0] fmaa_smin(input int unsigned ow);
        return ~fmaa_smax(ow);
    endfunction

    function automatic logic [FMAA_MAXW-1:0] fmaa_umax(input int unsigned ow);
        return (FMAA_MAXW'(1) << ow) - FMAA_MAXW'(1);
    endfunction

endpackage

// File: rtl/fmaa_pipe_stage.sv
// fmaa_pipe_stage -- one valid/ready register slice with bubble collapse.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake (in_ready is combinational)
//   in_data              : payload captured on transfer
//   out_valid/out_ready  : downstream handshake
//   out_data             : registered payload (cleared by reset)
module fmaa_pipe_stage
    import fmaa_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Empty slices always accept, so bubbles are squeezed out.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/fmaa_pipe.sv
// fmaa_pipe -- pipelined res = a*b +/- c +/- d (mod 2^OW) with exact overflow flag.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operation handshake; a, b, c, d, tc, neg_c, neg_d
//                         are sampled on transfer
//   out_valid/out_ready : result handshake
//   res, out_ovf        : result and "exact value not representable" flag
// Optional build macro FMAA_SATURATE_EN: clamp res to the nearest bound when
// out_ovf is set; otherwise res wraps modulo 2^OW.
// Slice 1 holds the product and the signed addends, slice 2 the final sum,
// further slices only delay. With STAGES=1 the sum is formed after slice 1.
module fmaa_pipe
    import fmaa_pkg::*;
#(
    parameter int unsigned BW     = 54,
    parameter int unsigned OW     = 3*BW+1,
    parameter int unsigned STAGES = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic [OW-1:0] c,
    input  logic [OW-1:0] d,
    input  logic          tc,
    input  logic          neg_c,
    input  logic          neg_d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] res,
    output logic          out_ovf
);

    // One guard bit beyond IW: with OW == 2*BW, unsigned a*b + c + d can reach
    // nearly 3*2^OW, which needs OW+2 magnitude bits plus a sign bit.
    localparam int unsigned IW = fmaa_iw(BW, OW);
    localparam int unsigned EW = IW + 1;
    localparam int unsigned P0 = 1 + 3*EW;
    localparam int unsigned P1 = 1 + EW;

    localparam logic signed [EW-1:0] SMAX = EW'(fmaa_smax(OW));
    localparam logic signed [EW-1:0] SMIN = EW'(fmaa_smin(OW));
    localparam logic signed [EW-1:0] UMAX = EW'(fmaa_umax(OW));

    fmaa_mode_t mode;
    logic signed [EW-1:0] ae, be, ce, de, prod, cv, dv;

    assign mode = '{tc: tc, neg_c: neg_c, neg_d: neg_d};

    always_comb begin
        ae   = mode.tc ? {{(EW-BW){a[BW-1]}}, a} : {{(EW-BW){1'b0}}, a};
        be   = mode.tc ? {{(EW-BW){b[BW-1]}}, b} : {{(EW-BW){1'b0}}, b};
        ce   = mode.tc ? {{(EW-OW){c[OW-1]}}, c} : {{(EW-OW){1'b0}}, c};
        de   = mode.tc ? {{(EW-OW){d[OW-1]}}, d} : {{(EW-OW){1'b0}}, d};
        prod = ae * be;
        cv   = mode.neg_c ? -ce : ce;
        dv   = mode.neg_d ? -de : de;
    end

    logic [P0-1:0] s0_in, s0_out;
    logic          s0_iready, s0_valid, s0_oready;
    logic [EW-1:0] r0_sum;
    logic [P1-1:0] r0;
    logic [P1-1:0] fin;
    logic          fin_valid;

    assign s0_in    = {mode.tc, prod, cv, dv};
    assign in_ready = s0_iready && !rst;

    fmaa_pipe_stage #(.W(P0)) u_s0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s0_iready),
        .in_data   (s0_in),
        .out_valid (s0_valid),
        .out_ready (s0_oready),
        .out_data  (s0_out)
    );

    assign r0_sum = s0_out[3*EW-1:2*EW] + s0_out[2*EW-1:EW] + s0_out[EW-1:0];
    assign r0     = {s0_out[P0-1], r0_sum};

    generate
        if (STAGES == 1) begin : g_one
            assign fin       = r0;
            assign fin_valid = s0_valid;
            assign s0_oready = out_ready;
        end else begin : g_more
            logic [P1-1:0] sd [1:STAGES-1];
            logic          sv [1:STAGES-1];
            logic          sr [1:STAGES-1];

            assign s0_oready = sr[1];

            for (genvar k = 1; k < STAGES; k++) begin : g_st
                logic [P1-1:0] din;
                logic          vin;
                logic          rdy;

                if (k == 1) begin : g_first
                    assign din = r0;
                    assign vin = s0_valid;
                end else begin : g_mid
                    assign din = sd[k-1];
                    assign vin = sv[k-1];
                end

                if (k == STAGES - 1) begin : g_last
                    assign rdy = out_ready;
                end else begin : g_inner
                    assign rdy = sr[k+1];
                end

                fmaa_pipe_stage #(.W(P1)) u_st (
                    .clk       (clk),
                    .rst       (rst),
                    .in_valid  (vin),
                    .in_ready  (sr[k]),
                    .in_data   (din),
                    .out_valid (sv[k]),
                    .out_ready (rdy),
                    .out_data  (sd[k])
                );
            end

            assign fin       = sd[STAGES-1];
            assign fin_valid = sv[STAGES-1];
        end
    endgenerate

    logic signed [EW-1:0] fsum;
    logic                 ftc;

    assign fsum      = fin[EW-1:0];
    assign ftc       = fin[P1-1];
    assign out_valid = fin_valid;

    // Reset clears the payload, so res and out_ovf read 0 after reset.
    always_comb begin
        if (ftc) begin
            out_ovf = (fsum > SMAX) || (fsum < SMIN);
        end else begin
            out_ovf = fsum[EW-1] || (fsum > UMAX);
        end
        res = fsum[OW-1:0];
`ifdef FMAA_SATURATE_EN
        if (out_ovf) begin
            if (ftc) begin
                res = fsum[EW-1] ? SMIN[OW-1:0] : SMAX[OW-1:0];
            end else begin
                res = fsum[EW-1] ? '0 : UMAX[OW-1:0];
            end
        end
`endif
    end

endmodule

// File: tb/tb_fmaa_pipe.sv
module tb_fmaa_pipe;

    localparam int unsigned BW = 4;
    localparam int unsigned OW = 13;
    localparam int unsigned ST = 3;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, tc, neg_c, neg_d;
    logic          out_valid, out_ready, out_ovf;
    logic [BW-1:0] a, b;
    logic [OW-1:0] c, d, res;

    fmaa_pipe #(.BW(BW), .OW(OW), .STAGES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .tc        (tc),
        .neg_c     (neg_c),
        .neg_d     (neg_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] r;
        logic          o;
    } rec_t;

    rec_t exp_q[$];
    rec_t got_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic          s_in_ready, s_out_valid, s_ovf, s_acc;
    logic [OW-1:0] s_res;

    // Reference: exact integer arithmetic, then range test and modulo.
    function automatic rec_t model(input logic [BW-1:0] fa, input logic [BW-1:0] fb,
                                   input logic [OW-1:0] fc, input logic [OW-1:0] fd,
                                   input logic ftc, input logic fnc, input logic fnd);
        longint ea, eb, ec, ed, v;
        rec_t   rr;
        ea = ftc ? longint'($signed(fa)) : longint'(fa);
        eb = ftc ? longint'($signed(fb)) : longint'(fb);
        ec = ftc ? longint'($signed(fc)) : longint'(fc);
        ed = ftc ? longint'($signed(fd)) : longint'(fd);
        v  = ea * eb + (fnc ? -ec : ec) + (fnd ? -ed : ed);
        if (ftc)
            rr.o = (v < -(longint'(1) << (OW-1))) || (v > (longint'(1) << (OW-1)) - 1);
        else
            rr.o = (v < 0) || (v > (longint'(1) << OW) - 1);
        rr.r = OW'(v);
`ifdef FMAA_SATURATE_EN
        if (rr.o) begin
            if (ftc) rr.r = (v < 0) ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
            else     rr.r = (v < 0) ? '0 : '1;
        end
`endif
        return rr;
    endfunction

    // Samples 1 time unit before the rising edge, then waits for the falling edge.
    task automatic tick();
        #4;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_res       = res;
        s_ovf       = out_ovf;
        s_acc       = in_valid && in_ready && !rst;
        if (!rst) begin
            if (s_acc) exp_q.push_back(model(a, b, c, d, tc, neg_c, neg_d));
            if (out_valid && out_ready) got_q.push_back('{r: res, o: out_ovf});
        end
        @(negedge clk);
        cyc++;
        if (rst) begin
            exp_q.delete();
            got_q.delete();
        end
    endtask

    task automatic set_idle();
        in_valid = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        tc = 1'b0; neg_c = 1'b0; neg_d = 1'b0;
    endtask

    task automatic set_op(input logic [BW-1:0] fa, input logic [BW-1:0] fb,
                          input logic [OW-1:0] fc, input logic [OW-1:0] fd,
                          input logic ftc, input logic fnc, input logic fnd);
        in_valid = 1'b1;
        a = fa; b = fb; c = fc; d = fd;
        tc = ftc; neg_c = fnc; neg_d = fnd;
    endtask

    function automatic logic [OW-1:0] rand_addend();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(OW-1){1'b0}}};
            3:       return {1'b0, {(OW-1){1'b1}}};
            default: return OW'($urandom);
        endcase
    endfunction

    task automatic set_rand();
        set_op(BW'($urandom), BW'($urandom), rand_addend(), rand_addend(),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        set_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 30 && (exp_q.size() != got_q.size() || out_valid); i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (s_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_during_rst: got %b want 0", s_in_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_after: got %b want 1", s_in_ready);
        end
        checks++;
        if (s_out_valid !== 1'b0 || s_res !== '0 || s_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b res=%0d ovf=%b want 0 0 0",
                     s_out_valid, s_res, s_ovf);
        end
    endtask

    task automatic test_basic();
        logic [BW-1:0] ta [4] = '{4'd15, 4'd0, 4'h8, 4'd0};
        logic [BW-1:0] tb [4] = '{4'd15, 4'd0, 4'h8, 4'd0};
        logic [OW-1:0] tcv[4] = '{13'd1, 13'd8191, 13'd8092, 13'd5};
        logic [OW-1:0] tdv[4] = '{13'd2, 13'd8191, 13'd10, 13'd0};
        logic          ttc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic          tnc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic          tnd[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef FMAA_SATURATE_EN
        logic [OW-1:0] er [4] = '{13'd228, 13'd8191, 13'd8146, 13'd0};
`else
        logic [OW-1:0] er [4] = '{13'd228, 13'd8190, 13'd8146, 13'd8187};
`endif
        logic          eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int acc_cyc, lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(ta[i], tb[i], tcv[i], tdv[i], ttc[i], tnc[i], tnd[i]);
            acc_cyc = cyc;
            tick();
            checks++;
            if (s_acc !== 1'b1) begin
                errors++;
                $display("FAIL basic_accept[%0d]: got %b want 1", i, s_acc);
            end
            set_idle();
            lat = -1;
            for (int t = 0; t < 10 && lat < 0; t++) begin
                int t0 = cyc;
                tick();
                if (s_out_valid) lat = t0 - acc_cyc;
            end
            checks++;
            if (lat != int'(ST)) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, ST);
            end
            checks++;
            if (s_res !== er[i] || s_ovf !== eo[i]) begin
                errors++;
                $display("FAIL basic_value[%0d]: got res=%0d ovf=%b want res=%0d ovf=%b",
                         i, s_res, s_ovf, er[i], eo[i]);
            end
            drain();
            exp_q.delete();
            got_q.delete();
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        set_rand();
        tick();
        set_idle();
        out_ready = 1'b0;
        tick();
        set_rand();
        tick();
        checks++;
        if (s_in_ready !== 1'b1 || s_acc !== 1'b1) begin
            errors++;
            $display("FAIL bubble_second_op: got in_ready=%b want 1", s_in_ready);
        end
        set_rand();
        tick();
        checks++;
        if (s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bubble_third_op: got in_ready=%b want 1", s_in_ready);
        end
        set_rand();
        tick();
        checks++;
        if (s_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bubble_full: got in_ready=%b want 0", s_in_ready);
        end
        drain();
        checks++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL bubble_count: got %0d results want 3 (expected %0d)",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bubble_result[%0d]: got res=%0d ovf=%b want res=%0d ovf=%b",
                         i, got_q[i].r, got_q[i].o, exp_q[i].r, exp_q[i].o);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        int            idx = 0;
        logic [OW-1:0] held_res = '0;
        logic          held_ovf = 1'b0;
        logic          have_held = 1'b0;
        out_ready = 1'b0;
        set_rand();
        for (int t = 0; t < 40 && idx < 6; t++) begin
            out_ready = (t >= 6);
            tick();
            if (t >= 3 && t <= 5) begin
                checks++;
                if (s_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full_in_ready[t=%0d]: got %b want 0", t, s_in_ready);
                end
                checks++;
                if (s_out_valid !== 1'b1 || (have_held && (s_res !== held_res || s_ovf !== held_ovf))) begin
                    errors++;
                    $display("FAIL bp_stable[t=%0d]: got valid=%b res=%0d ovf=%b want 1 %0d %b",
                             t, s_out_valid, s_res, s_ovf, held_res, held_ovf);
                end
                held_res  = s_res;
                held_ovf  = s_ovf;
                have_held = 1'b1;
            end
            if (t == 6) begin
                checks++;
                if (s_in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_pass_through: got in_ready=%b want 1", s_in_ready);
                end
            end
            if (s_acc) begin
                idx++;
                if (idx < 6) set_rand();
                else set_idle();
            end
        end
        drain();
        checks++;
        if (got_q.size() != 6 || exp_q.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d results want 6 (expected %0d)",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_result[%0d]: got res=%0d ovf=%b want res=%0d ovf=%b",
                         i, got_q[i].r, got_q[i].o, exp_q[i].r, exp_q[i].o);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        int max_inflight = 0;
        set_idle();
        for (int t = 0; t < 400; t++) begin
            if (!in_valid || s_acc) begin
                if ($urandom_range(0, 3) != 0) set_rand();
                else set_idle();
            end
            out_ready = ($urandom_range(0, 9) < 7);
            s_acc = 1'b0;
            tick();
            if (exp_q.size() - got_q.size() > max_inflight)
                max_inflight = exp_q.size() - got_q.size();
        end
        drain();
        checks++;
        if (max_inflight > int'(ST)) begin
            errors++;
            $display("FAIL rand_inflight: got %0d want <= %0d", max_inflight, ST);
        end
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin
            errors++;
            $display("FAIL rand_count: got %0d results want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_result[%0d]: got res=%0d ovf=%b want res=%0d ovf=%b",
                         i, got_q[i].r, got_q[i].o, exp_q[i].r, exp_q[i].o);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        out_ready = 1'b1;
        set_op(4'd7, 4'd3, 13'd100, 13'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_op(4'd5, 4'd5, 13'd1, 13'd1, 1'b1, 1'b0, 1'b0);
        tick();
        set_idle();
        rst = 1'b1;
        tick();
        checks++;
        if (s_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_ready_during: got %b want 0", s_in_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (s_out_valid !== 1'b0 || s_res !== '0 || s_ovf !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got valid=%b res=%0d ovf=%b want 0 0 0",
                     s_out_valid, s_res, s_ovf);
        end
        checks++;
        if (s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_ready_after: got %b want 1", s_in_ready);
        end
        for (int t = 0; t < 6; t++) begin
            tick();
            if (s_out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midrst_stale: got %0d stale results want 0", stale);
        end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        s_acc     = 1'b0;
        set_idle();
        @(negedge clk);
        test_reset();
        test_basic();
        test_bubble();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
